// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared state encoding and sizing constants for seq_divider
package seq_div_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one unsigned restoring-division step (shift, trial subtract, restore)
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // rem_in < divisor always holds, so the borrow out of diff is the compare result
    always_comb begin
        trial   = {rem_in, bit_in};
        diff    = trial - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - signed 2W/W sequential restoring divider with overflow and div-by-zero
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [WIDTH-1:0]  raw_lo_q, raw_lo_d;
    logic              neg_dvd_q, neg_dvd_d;
    logic              neg_dvs_q, neg_dvs_d;
    logic              dz_q, dz_d;
    logic              pov_q, pov_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  quotient_q, quotient_d;
    logic [WIDTH-1:0]  remainder_q, remainder_d;
    logic              dbz_q, dbz_d;
    logic              ovf_q, ovf_d;

    logic [2*WIDTH:0]  dvd_ext, abs_dvd;
    logic [WIDTH:0]    dvs_ext, abs_dvs;
    logic [WIDTH-1:0]  step_rem;
    logic              step_q;
    logic              q_neg;
    logic              post_ovf;

    // One extra bit so the magnitude of the most negative value does not wrap
    assign dvd_ext = {dividend[2*WIDTH-1], dividend};
    assign dvs_ext = {divisor[WIDTH-1], divisor};
    assign abs_dvd = dividend[2*WIDTH-1] ? -dvd_ext : dvd_ext;
    assign abs_dvs = divisor[WIDTH-1] ? -dvs_ext : dvs_ext;

    assign q_neg    = neg_dvd_q ^ neg_dvs_q;
    assign post_ovf = (quo_q > HALF) || ((quo_q == HALF) && !q_neg);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .bit_in  (lo_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        lo_d        = lo_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        raw_lo_d    = raw_lo_q;
        neg_dvd_d   = neg_dvd_q;
        neg_dvs_d   = neg_dvs_q;
        dz_d        = dz_q;
        pov_d       = pov_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            IDLE: begin
                // Operands land on the accepting edge; the path decision follows one cycle later
                if (pend_q) begin
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                    quo_d   = '0;
                    state_d = (dz_q || pov_q) ? FIX : CALC;
                end else if (start) begin
                    pend_d    = 1'b1;
                    rem_d     = abs_dvd[2*WIDTH-1:WIDTH];
                    lo_d      = abs_dvd[WIDTH-1:0];
                    dvs_d     = abs_dvs[WIDTH-1:0];
                    raw_lo_d  = dividend[WIDTH-1:0];
                    neg_dvd_d = dividend[2*WIDTH-1];
                    neg_dvs_d = divisor[WIDTH-1];
                    dz_d      = (divisor == '0);
                    pov_d     = (divisor != '0) && (abs_dvd[2*WIDTH:WIDTH] >= abs_dvs);
                end
            end
            CALC: begin
                rem_d = step_rem;
                lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                quo_d = {quo_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz_q) begin
                    quotient_d  = '1;
                    remainder_d = raw_lo_q;
                    dbz_d       = 1'b1;
                    ovf_d       = 1'b0;
                end else if (pov_q || post_ovf) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b1;
                end else begin
                    quotient_d  = q_neg ? -quo_q : quo_q;
                    remainder_d = neg_dvd_q ? -rem_q : rem_q;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            rem_q       <= '0;
            lo_q        <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            raw_lo_q    <= '0;
            neg_dvd_q   <= 1'b0;
            neg_dvs_q   <= 1'b0;
            dz_q        <= 1'b0;
            pov_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            lo_q        <= lo_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            raw_lo_q    <= raw_lo_d;
            neg_dvd_q   <= neg_dvd_d;
            neg_dvs_q   <= neg_dvs_d;
            dz_q        <= dz_d;
            pov_q       <= pov_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed-vector bench for seq_divider at WIDTH=32
module tb_seq_divider;

    localparam int W = 32;

    logic           clk;
    logic           reset;
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_q"}, 64'(quotient), 64'd0);
        check_eq({tag, "_r"}, 64'(remainder), 64'd0);
        check_eq({tag, "_dz"}, 64'(div_by_zero), 64'd0);
        check_eq({tag, "_ov"}, 64'(overflow), 64'd0);
    endtask

    task automatic run_div(input string tag, input logic [63:0] a, input logic [31:0] b,
                           input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input logic eov);
        int lat;
        lat = -1;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_q"}, 64'(quotient), 64'(eq));
        check_eq({tag, "_r"}, 64'(remainder), 64'(er));
        check_eq({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
        check_eq({tag, "_ov"}, 64'(overflow), 64'(eov));
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse"}, 64'(done), 64'd0);
        check_eq({tag, "_hold_q"}, 64'(quotient), 64'(eq));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ndone;
        int lat;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        run_div("pos_10_5",   64'd10,       32'd5,       34, 32'd2,          32'd0,          1'b0, 1'b0);
        run_div("neg_42_6",   64'(-42),     32'd6,       34, 32'(-7),        32'd0,          1'b0, 1'b0);
        run_div("neg_7_2",    64'(-7),      32'd2,       34, 32'(-3),        32'(-1),        1'b0, 1'b0);
        run_div("pos_7_n2",   64'd7,        32'(-2),     34, 32'(-3),        32'd1,          1'b0, 1'b0);
        run_div("dz_7_0",     64'd7,        32'd0,       2,  32'hFFFF_FFFF,  32'd7,          1'b1, 1'b0);
        run_div("pre_ov",     64'h100_0000_0000, 32'd1,  2,  32'd0,          32'd0,          1'b0, 1'b1);
        run_div("zero_dvd",   64'd0,        32'd5,       34, 32'd0,          32'd0,          1'b0, 1'b0);
        run_div("post_ov",    64'h8000_0000, 32'd1,      34, 32'd0,          32'd0,          1'b0, 1'b1);
        run_div("most_neg",   64'hFFFF_FFFF_8000_0000, 32'd1, 34, 32'h8000_0000, 32'd0,    1'b0, 1'b0);

        // second start during CALC is dropped; previous result still visible meanwhile
        @(negedge clk);
        dividend = 64'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_busy", 64'(busy), 64'd1);
        check_eq("mid_hold_q", 64'(quotient), 64'h8000_0000);
        dividend = 64'd1;
        divisor  = 32'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int i = 7; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check_eq("mid_lat", 64'(lat), 64'd34);
        check_eq("mid_q", 64'(quotient), 64'd14);
        check_eq("mid_r", 64'(remainder), 64'd2);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check_eq("mid_no_requeue", 64'(ndone), 64'd0);

        // reset at N+10 aborts the operation in flight
        @(negedge clk);
        dividend = 64'd50;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_outputs_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check_eq("abort_no_done", 64'(ndone), 64'd0);

        run_div("post_rst_9_4", 64'd9,   32'd4, 34, 32'd2,    32'd1,    1'b0, 1'b0);
        run_div("neg_9_4",      64'(-9), 32'd4, 34, 32'(-2),  32'(-1),  1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 32: width of the divisor, quotient and remainder; the dividend is 2*WIDTH.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port start, input, 1: request a division; sampled only in IDLE.
REQ-005 Port dividend, input, 2*WIDTH: signed two's-complement dividend; sampled with start.
REQ-006 Port divisor, input, WIDTH: signed two's-complement divisor; sampled with start.
REQ-007 Port busy, output, 1: high in the CALC and FIX states.
REQ-008 Port done, output, 1: one-cycle pulse, high only in the DONE state.
REQ-009 Port quotient, output, WIDTH: signed quotient, truncated toward zero.
REQ-010 Port remainder, output, WIDTH: signed remainder; carries the dividend's sign.
REQ-011 Port div_by_zero, output, 1: the last operation had divisor == 0.
REQ-012 Port overflow, output, 1: the last quotient does not fit in a signed WIDTH-bit value.

Function
REQ-013 States SHALL be IDLE, CALC, FIX and DONE.
- IDLE->CALC on start.
- CALC->FIX after exactly WIDTH iterations.
- FIX->DONE unconditionally.
- DONE->IDLE unconditionally.
REQ-014 Operands SHALL be captured at the accepting edge N; later input changes SHALL NOT affect the operation in flight.
REQ-015 start SHALL be ignored in CALC, FIX and DONE; there is no queueing.
REQ-016 CALC SHALL perform one unsigned restoring-division step per cycle on |dividend| and |divisor|, producing one quotient bit MSB-first.
REQ-017 Normal latency: done SHALL be high in the cycle after edge N+WIDTH+2; quotient, remainder and flags SHALL be valid in that same cycle.
REQ-018 Fast path for divisor == 0 or precheck overflow: IDLE SHALL go directly to FIX at N+1, so done is high after edge N+2.
REQ-019 Divide by zero SHALL produce: div_by_zero=1, quotient=all ones (-1), remainder=dividend[WIDTH-1:0], overflow=0.
REQ-020 Precheck overflow: upper WIDTH bits of |dividend| >= |divisor| SHALL give overflow=1, quotient=0, remainder=0.
REQ-021 Post-check in FIX:
- Unsigned quotient magnitude > 2^(WIDTH-1) SHALL set overflow.
- Magnitude == 2^(WIDTH-1) with a positive result SHALL set overflow.
- Magnitude == 2^(WIDTH-1) with a negative result is legal (most-negative value).
REQ-022 FIX SHALL negate the quotient when the operand signs differ, and negate the remainder when the dividend is negative.
REQ-023 |most-negative| SHALL be computed in WIDTH+1 / 2*WIDTH+1 bits so that no wrap-around occurs.
REQ-024 quotient, remainder, div_by_zero and overflow SHALL hold their values until the FIX state of the next operation.
REQ-025 A zero dividend SHALL yield quotient=0 and remainder=0 with normal latency.

Reset
REQ-026 On reset: state=IDLE; busy, done, quotient, remainder, div_by_zero and overflow all =0; iteration counter=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation immediately with no done pulse.
REQ-028 After reset deassertion, the first start edge SHALL be accepted.

Structure
REQ-029 Package seq_div_pkg SHALL hold:
- the state enum (IDLE, CALC, FIX, DONE);
- the default WIDTH constant;
- the counter width $clog2(WIDTH+1).
REQ-030 Sub-module div_step SHALL be the combinational shift/compare/subtract step:
- in: partial remainder, next dividend bit, divisor;
- out: new remainder and quotient bit.
REQ-031 Sign handling and overflow SHALL remain in the top-level seq_divider.

Verification (WIDTH=32)
REQ-032 Scenario: dividend=10, divisor=5, start at edge N -> done after N+34, quotient=2, remainder=0, flags=0.
REQ-033 Scenario: -42/6 -> quotient=-7, remainder=0; then -7/2 -> quotient=-3, remainder=-1; then 7/-2 -> quotient=-3, remainder=1.
REQ-034 Scenario: 7/0 -> done after N+2, div_by_zero=1, quotient=-1, remainder=7.
REQ-035 Scenario: 2^40/1 -> done after N+2, overflow=1; also -2^31/1 -> quotient=-2^31 with overflow=0, and 2^31/1 -> overflow=1.
REQ-036 Scenario: pulse start again during CALC -> ignored, first result unchanged; reset at N+10 -> busy=0, no done pulse, all outputs=0.
REQ-037 Every scenario SHALL be checked against a reference model, with pass/fail totals reported at end of run.
